// File: rtl/zx_rom_pkg.sv
// Shared definitions for the ZX ROM store: image geometry, loader state encoding
// and the byte-lane convention used when packing bytes into 16-bit words.
package zx_rom_pkg;

  localparam int ZX_ROM_BYTES = 16384;
  localparam int ZX_ROM_WORDS = ZX_ROM_BYTES / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WR,
    ST_DONE
  } loader_state_t;

  // Little-endian packing: the even byte lives in the low lane.
  localparam int LANE_EVEN_LSB = 0;
  localparam int LANE_ODD_LSB  = 8;

endpackage

// File: rtl/zx_rom_loader.sv
// Streams a boot image into the ZX ROM store as little-endian 16-bit words and
// holds the Z80 in reset until every word has been written.
module zx_rom_loader
  import zx_rom_pkg::*;
#(
  parameter int ROM_BYTES = ZX_ROM_BYTES,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_wen,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_resetn,
  output logic [15:0]       checksum
);

  localparam int CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ROM_BYTES / 2 - 1);

  loader_state_t     r_state;
  loader_state_t     w_next_state;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [15:0]       r_rom_wdata;
  logic              r_rom_wen;
  logic [15:0]       r_checksum;
  logic              w_in_ready;
  logic              w_start_load;
  logic              w_accept;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_start_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_LO;
          w_start_load = 1'b1;
        end
      end
      ST_LO: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next_state = ST_HI;
      end
      ST_HI: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next_state = ST_WR;
      end
      ST_WR: begin
        w_next_state = (r_word_cnt == LAST_WORD) ? ST_DONE : ST_LO;
      end
      ST_DONE: begin
        if (start) begin
          w_next_state = ST_LO;
          w_start_load = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = w_in_ready & in_valid;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_word_cnt  <= '0;
      r_rom_addr  <= '0;
      r_rom_wdata <= '0;
      r_rom_wen   <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_rom_wen <= w_accept && (r_state == ST_HI);

      if (w_start_load) begin
        r_word_cnt <= '0;
        r_checksum <= '0;
      end else begin
        if (w_accept)           r_checksum <= r_checksum + {8'h00, in_data};
        if (r_state == ST_WR)   r_word_cnt <= r_word_cnt + 1'b1;
      end

      if (w_accept && (r_state == ST_LO))
        r_rom_wdata[LANE_EVEN_LSB +: 8] <= in_data;

      // Address is captured with the odd byte so it is registered during WR and
      // holds afterwards while the counter moves on.
      if (w_accept && (r_state == ST_HI)) begin
        r_rom_wdata[LANE_ODD_LSB +: 8] <= in_data;
        r_rom_addr                     <= {1'b0, r_word_cnt};
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign rom_wen    = r_rom_wen;
  assign rom_addr   = r_rom_addr;
  assign rom_wdata  = r_rom_wdata;
  assign busy       = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_WR);
  assign done       = (r_state == ST_DONE);
  assign cpu_resetn = (r_state == ST_DONE);
  assign checksum   = r_checksum;

endmodule

// File: tb/tb_zx_rom_loader.sv
// Directed self-checking bench for zx_rom_loader: handshake, packing, checksum,
// full 16 KB load, restart rules and asynchronous reset.
module tb_zx_rom_loader;
  import zx_rom_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_wen;
  logic [13:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        busy;
  logic        done;
  logic        cpu_resetn;
  logic [15:0] checksum;

  zx_rom_loader #(.ROM_BYTES(ZX_ROM_BYTES), .ADDR_W(14)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rom_wen    (rom_wen),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .busy       (busy),
    .done       (done),
    .cpu_resetn (cpu_resetn),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  cyc         = 0;
  int  ready_in_wr = 0;
  int  wen_double  = 0;
  logic prev_wen   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rom_wen) begin
      wr_q.push_back('{rom_addr, rom_wdata, cyc});
      if (in_ready) ready_in_wr++;
      if (prev_wen) wen_double++;
    end
    prev_wen <= rom_wen;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte and returns on the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(n), 32'd0);
      return;
    end
    @(negedge clk);
  endtask

  logic [7:0] gap_bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [15:0] gap_words [4] = '{16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    resetn   = 1'b1;

    // Idle with a valid byte offered but no start.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check("idle_in_ready",   in_ready,   0);
    check("idle_rom_wen",    rom_wen,    0);
    check("idle_cpu_resetn", cpu_resetn, 0);
    check("idle_checksum",   checksum,   0);
    check("idle_busy",       busy,       0);
    check("idle_done",       done,       0);
    check("idle_wr_count",   wr_q.size(), 0);
    in_valid = 1'b0;

    // Two gapless words.
    pulse_start();
    check("load_busy",       busy,       1);
    check("load_cpu_resetn", cpu_resetn, 0);
    send_byte(8'hF3, 0);
    send_byte(8'hAF, 0);
    send_byte(8'h11, 0);
    send_byte(8'hFF, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("two_wr_count", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("w0_addr", wr_q[0].addr, 14'd0);
      check("w0_data", wr_q[0].data, 16'hAFF3);
      check("w1_addr", wr_q[1].addr, 14'd1);
      check("w1_data", wr_q[1].data, 16'hFF11);
      check("word_spacing", 32'(wr_q[1].cyc - wr_q[0].cyc), 3);
    end
    check("two_checksum", checksum, 16'h02B2);
    check("wen_one_cycle", wen_double, 0);

    // start while busy is ignored.
    pulse_start();
    check("restart_busy_busy",     busy,     1);
    check("restart_busy_checksum", checksum, 16'h02B2);
    wr_q.delete();

    // Eight bytes with random valid gaps continue at word 2.
    foreach (gap_bytes[i]) send_byte(gap_bytes[i], 1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("gap_wr_count", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      foreach (gap_words[k]) begin
        check($sformatf("gap_w%0d_addr", k), wr_q[k].addr, 14'(2 + k));
        check($sformatf("gap_w%0d_data", k), wr_q[k].data, gap_words[k]);
      end
    end
    check("gap_checksum", checksum, 16'h06EA);
    check("ready_in_wr",  ready_in_wr, 0);

    // Asynchronous reset after three bytes.
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_in_ready",   in_ready,   0);
    check("rst_rom_wen",    rom_wen,    0);
    check("rst_rom_addr",   rom_addr,   0);
    check("rst_rom_wdata",  rom_wdata,  0);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_cpu_resetn", cpu_resetn, 0);
    check("rst_checksum",   checksum,   0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    wr_q.delete();

    // Full gapless load; start is pulsed on the final WR cycle.
    pulse_start();
    for (int i = 0; i < ZX_ROM_BYTES; i++) send_byte(8'(i), 0);
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    check("full_wr_count", wr_q.size(), ZX_ROM_WORDS);
    if (wr_q.size() == ZX_ROM_WORDS) begin
      errs = 0;
      for (int w = 0; w < ZX_ROM_WORDS; w++) begin
        if (wr_q[w].addr !== 14'(w) || wr_q[w].data !== {8'(2 * w + 1), 8'(2 * w)}) errs++;
      end
      check("full_word_errors", errs, 0);
      check("first_wdata", wr_q[0].data, 16'h0100);
      check("last_addr",   wr_q[ZX_ROM_WORDS-1].addr, 14'h1FFF);
      check("last_wdata",  wr_q[ZX_ROM_WORDS-1].data, 16'hFFFE);
      check("full_span", 32'(wr_q[ZX_ROM_WORDS-1].cyc - wr_q[0].cyc), 3 * (ZX_ROM_WORDS - 1));
    end
    check("done_done",       done,       1);
    check("done_cpu_resetn", cpu_resetn, 1);
    check("done_busy",       busy,       0);
    check("done_checksum",   checksum,   16'hE000);
    check("done_in_ready",   in_ready,   0);
    repeat (3) @(negedge clk);
    check("done_hold_checksum", checksum,    16'hE000);
    check("done_hold_wr_count", wr_q.size(), ZX_ROM_WORDS);
    check("done_hold_done",     done,        1);
    in_valid = 1'b0;
    wr_q.delete();

    // start from DONE restarts at word 0.
    pulse_start();
    check("again_done",       done,       0);
    check("again_cpu_resetn", cpu_resetn, 0);
    check("again_busy",       busy,       1);
    check("again_checksum",   checksum,   0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("again_wr_count", wr_q.size(), 1);
    if (wr_q.size() == 1) begin
      check("again_addr", wr_q[0].addr, 14'd0);
      check("again_data", wr_q[0].data, 16'h1234);
    end
    check("again_checksum_after", checksum, 16'h0046);
    check("final_ready_in_wr", ready_in_wr, 0);
    check("final_wen_one_cycle", wen_double, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
